async_valid_sync: RTL and testbench



---
 rtl/async_valid_sync_pkg.sv | 8 +
 rtl/async_reset_synchronizer_shift_reg_w1_d3_i0.sv | 45 ++++
 rtl/async_valid_sync.sv | 31 +++
 tb/tb_async_valid_sync.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/async_valid_sync_pkg.sv
// Shared constants for the valid-flag synchronizer: the default chain depth and
// the value every stage takes on reset.
package async_valid_sync_pkg;

    localparam int   SYNC_DEPTH = 3;
    localparam logic SYNC_INIT  = 1'b0;

endpackage

// File: rtl/async_reset_synchronizer_shift_reg_w1_d3_i0.sv
// Generic DEPTH x WIDTH synchronizer shift chain. Each stage is its own named flop
// (g_sync[N].r_sync) so timing constraints can target the chain directly.
module async_reset_synchronizer_shift_reg_w1_d3_i0
    import async_valid_sync_pkg::*;
#(
    parameter int   DEPTH = SYNC_DEPTH,
    parameter int   WIDTH = 1,
    parameter logic INIT  = SYNC_INIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_d,
    output logic [WIDTH-1:0] io_q
);

    logic [DEPTH-1:0][WIDTH-1:0] w_stage_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sync
            logic [WIDTH-1:0] w_stage_d;
            (* async_reg = "true" *) logic [WIDTH-1:0] r_sync;

            // Highest-numbered stage captures the asynchronous input.
            if (gi == DEPTH - 1) begin : g_head
                assign w_stage_d = io_d;
            end else begin : g_body
                assign w_stage_d = w_stage_q[gi+1];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sync <= {WIDTH{INIT}};
                end else begin
                    r_sync <= w_stage_d;
                end
            end

            assign w_stage_q[gi] = r_sync;
        end
    endgenerate

    assign io_q = w_stage_q[0];

endmodule

// File: rtl/async_valid_sync.sv
// Valid/handshake flag synchronizer: a thin wrapper around the shift chain that
// renames its ports; io_out is io_in delayed by DEPTH rising edges.
module async_valid_sync
    import async_valid_sync_pkg::*;
#(
    parameter int   DEPTH = SYNC_DEPTH,
    parameter int   WIDTH = 1,
    parameter logic INIT  = SYNC_INIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out
);

    logic [WIDTH-1:0] w_sync_q;

    async_reset_synchronizer_shift_reg_w1_d3_i0 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_chain (
        .clock (clock),
        .reset (reset),
        .io_d  (io_in),
        .io_q  (w_sync_q)
    );

    assign io_out = w_sync_q;

endmodule

// File: tb/tb_async_valid_sync.sv
// Bench for async_valid_sync: directed vector table on the default DEPTH=3 instance,
// a DEPTH/WIDTH step sweep, and randomized traffic against a history-based model.
module tb_async_valid_sync;

    logic       clock;
    logic       reset;
    logic       io_in;
    logic [3:0] io_in4;
    logic       out_d3, out_d1, out_d2, out_d4;
    logic [3:0] out_w4;

    int checks = 0;
    int passes = 0;

    // Edge-indexed history of what the chain sampled: the model reads this back.
    localparam int HMAX = 4096;
    logic [3:0] hist_in  [HMAX];
    logic       hist_rst [HMAX];
    int         n_edges = 0;

    async_valid_sync dut (
        .clock(clock), .reset(reset), .io_in(io_in), .io_out(out_d3)
    );
    async_valid_sync #(.DEPTH(1), .WIDTH(1), .INIT(1'b0)) dut_d1 (
        .clock(clock), .reset(reset), .io_in(io_in), .io_out(out_d1)
    );
    async_valid_sync #(.DEPTH(2), .WIDTH(1), .INIT(1'b0)) dut_d2 (
        .clock(clock), .reset(reset), .io_in(io_in), .io_out(out_d2)
    );
    async_valid_sync #(.DEPTH(4), .WIDTH(1), .INIT(1'b0)) dut_d4 (
        .clock(clock), .reset(reset), .io_in(io_in), .io_out(out_d4)
    );
    async_valid_sync #(.DEPTH(3), .WIDTH(4), .INIT(1'b0)) dut_w4 (
        .clock(clock), .reset(reset), .io_in(io_in4), .io_out(out_w4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply inputs, take one rising edge, log what was sampled, settle 1ns.
    task automatic tick(input logic rst, input logic [3:0] din);
        reset  = rst;
        io_in  = din[0];
        io_in4 = din;
        @(posedge clock);
        hist_in[n_edges]  = din;
        hist_rst[n_edges] = rst;
        n_edges++;
        #1;
    endtask

    // Output after the latest edge: zero if any of the last d edges saw reset,
    // otherwise the input sampled d-1 edges before the latest one.
    function automatic logic [3:0] model(input int d);
        int e;
        e = n_edges - 1;
        for (int k = e - d + 1; k <= e; k++) begin
            if (hist_rst[k]) return 4'h0;
        end
        return hist_in[e - d + 1];
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, n_edges);
        end
    endtask

    typedef struct {
        logic rst;
        logic din;
        logic exp_out;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic r, input logic d, input logic e);
        vec_t v;
        v.rst = r; v.din = d; v.exp_out = e;
        vecs.push_back(v);
    endtask

    initial begin
        int lat [5];
        logic [3:0] act;

        reset  = 1'b1;
        io_in  = 1'b0;
        io_in4 = 4'h0;

        // Reset held 2 edges with io_in=1, released: 1 appears after 3rd edge.
        add(1,1,0); add(1,1,0); add(0,1,0); add(0,1,0); add(0,1,1);
        // Drain to zero.
        add(0,0,1); add(0,0,1); add(0,0,0); add(0,0,0);
        // Single-cycle pulse comes out as a single-cycle pulse 3 edges later.
        add(0,1,0); add(0,0,0); add(0,0,1); add(0,0,0); add(0,0,0);
        // Toggle pattern shifted by 3.
        add(0,1,0); add(0,0,0); add(0,1,1); add(0,0,0); add(0,1,1); add(0,0,0);
        // Fill with ones, then a 1-edge reset discards the chain.
        add(0,1,1); add(0,1,0); add(0,1,1); add(0,1,1); add(0,1,1);
        add(1,1,0); add(0,1,0); add(0,1,0); add(0,1,1);
        // Drain, then reset on the same edge io_in rises: the 1 is lost.
        add(0,0,1); add(0,0,1); add(0,0,0);
        add(1,1,0); add(0,0,0); add(0,0,0); add(0,0,0);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, {3'b000, vecs[i].din});
            $display("vec %0d: reset=%0b io_in=%0b io_out=%0b expect=%0b",
                     i, vecs[i].rst, vecs[i].din, out_d3, vecs[i].exp_out);
            check($sformatf("vec%0d", i), {3'b000, out_d3}, {3'b000, vecs[i].exp_out});
        end

        // Step sweep: measure edges from the 0->1 step until each output changes.
        tick(1'b1, 4'h0); tick(1'b1, 4'h0);
        tick(1'b0, 4'h0); tick(1'b0, 4'h0); tick(1'b0, 4'h0); tick(1'b0, 4'h0);
        foreach (lat[i]) lat[i] = 0;
        for (int c = 1; c <= 8; c++) begin
            tick(1'b0, 4'hB);
            if (lat[0] == 0 && out_d1 === 1'b1) lat[0] = c;
            if (lat[1] == 0 && out_d2 === 1'b1) lat[1] = c;
            if (lat[2] == 0 && out_d3 === 1'b1) lat[2] = c;
            if (lat[3] == 0 && out_d4 === 1'b1) lat[3] = c;
            if (lat[4] == 0 && out_w4 === 4'hB) lat[4] = c;
        end
        $display("step: latency d1=%0d d2=%0d d3=%0d d4=%0d w4=%0d",
                 lat[0], lat[1], lat[2], lat[3], lat[4]);
        check("lat_d1", 4'(lat[0]), 4'd1);
        check("lat_d2", 4'(lat[1]), 4'd2);
        check("lat_d3", 4'(lat[2]), 4'd3);
        check("lat_d4", 4'(lat[3]), 4'd4);
        check("lat_w4", 4'(lat[4]), 4'd3);

        // Randomized traffic with occasional resets, all instances against the model.
        tick(1'b1, 4'h0); tick(1'b1, 4'h0);
        for (int t = 0; t < 400; t++) begin
            tick(($urandom_range(0, 19) == 0), 4'($urandom));
            act = {3'b000, out_d1}; check("rand_d1", act, model(1) & 4'h1);
            act = {3'b000, out_d2}; check("rand_d2", act, model(2) & 4'h1);
            act = {3'b000, out_d3}; check("rand_d3", act, model(3) & 4'h1);
            act = {3'b000, out_d4}; check("rand_d4", act, model(4) & 4'h1);
            check("rand_w4", out_w4, model(3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
